// File: rtl/oled_spi_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_rx_if
// Brief    : 4-wire SSD1306-style OLED SPI pin bundle (sck, mosi, dc, cs_n).
// Revision : 1.0 - initial release
// ============================================================================
interface oled_spi_rx_if;
    logic sck;
    logic mosi;
    logic dc;
    logic cs_n;

    modport master (output sck, output mosi, output dc, output cs_n);
    modport slave  (input  sck, input  mosi, input  dc, input  cs_n);
endinterface
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_rx
// Brief    : OLED SPI receiver; deserialises bytes, decodes SSD1306 commands
//            and generates GRAM write strobes. Optional OLED_RX_FRAME_DONE_EN
//            builds the end-of-frame detector.
// Revision : 1.0 - initial release
// ============================================================================
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    oled_spi_rx_if.slave       spi,
    output logic               o_byte_valid,
    output logic [7:0]         o_byte_data,
    output logic               o_byte_dc,
    output logic               o_disp_on,
    output logic               o_entire_on,
    output logic               o_charge_pump,
    output logic [7:0]         o_contrast,
    output logic [7:0]         o_precharge,
    output logic [1:0]         o_addr_mode,
    output logic               o_wr_en,
    output logic [2:0]         o_wr_page,
    output logic [6:0]         o_wr_col,
    output logic [7:0]         o_wr_data,
    output logic               o_cmd_err,
    output logic               o_frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARG1 = 2'd1;
    localparam logic [1:0] S_ARG2 = 2'd2;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic                   r_sck_d;
    logic                   w_sck_s;
    logic                   w_mosi_s;
    logic                   w_dc_s;
    logic                   w_csn_s;
    logic                   w_rise;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_byte_dc;

    logic [1:0] r_state;
    logic [7:0] r_opcode;
    logic [6:0] r_arg1;
    logic       r_disp_on;
    logic       r_entire_on;
    logic       r_charge_pump;
    logic [7:0] r_contrast;
    logic [7:0] r_precharge;
    logic [1:0] r_addr_mode;
    logic [6:0] r_col_start;
    logic [6:0] r_col_end;
    logic [2:0] r_page_start;
    logic [2:0] r_page_end;
    logic [6:0] r_col;
    logic [2:0] r_page;
    logic [6:0] w_col_nxt;
    logic [2:0] w_page_nxt;
    logic       r_wr_en;
    logic [2:0] r_wr_page;
    logic [6:0] r_wr_col;
    logic [7:0] r_wr_data;
    logic       r_cmd_err;

    // Sync chains reset to the idle bus level so reset release cannot fake an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
            r_csn_sync  <= '1;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  spi.sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   spi.dc};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  spi.cs_n};
            r_sck_d     <= w_sck_s;
        end
    end

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];
    assign w_csn_s  = r_csn_sync[SYNC_STAGES-1];
    assign w_rise   = w_sck_s & ~r_sck_d & ~w_csn_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'd0;
            r_byte_dc    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_csn_s) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte_data  <= {r_shift, w_mosi_s};
                    r_byte_dc    <= w_dc_s;
                end
            end
        end
    end

    // Pointer advance; equality-only wrap keeps start > end windows on the natural wrap.
    always_comb begin
        w_col_nxt  = r_col;
        w_page_nxt = r_page;
        case (r_addr_mode)
            2'b00: begin
                if (r_col == r_col_end) begin
                    w_col_nxt  = r_col_start;
                    w_page_nxt = (r_page == r_page_end) ? r_page_start : r_page + 3'd1;
                end else begin
                    w_col_nxt  = r_col + 7'd1;
                end
            end
            2'b01: begin
                if (r_page == r_page_end) begin
                    w_page_nxt = r_page_start;
                    w_col_nxt  = (r_col == r_col_end) ? r_col_start : r_col + 7'd1;
                end else begin
                    w_page_nxt = r_page + 3'd1;
                end
            end
            default: begin
                w_col_nxt = (r_col == r_col_end) ? r_col_start : r_col + 7'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= 8'd0;
            r_arg1        <= 7'd0;
            r_disp_on     <= 1'b0;
            r_entire_on   <= 1'b0;
            r_charge_pump <= 1'b0;
            r_contrast    <= 8'h7F;
            r_precharge   <= 8'h22;
            r_addr_mode   <= 2'b10;
            r_col_start   <= 7'd0;
            r_col_end     <= 7'd127;
            r_page_start  <= 3'd0;
            r_page_end    <= 3'd7;
            r_col         <= 7'd0;
            r_page        <= 3'd0;
            r_wr_en       <= 1'b0;
            r_wr_page     <= 3'd0;
            r_wr_col      <= 7'd0;
            r_wr_data     <= 8'd0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_cmd_err <= 1'b0;
            if (r_byte_valid) begin
                if (r_byte_dc) begin
                    // A data byte aborts any pending argument, then is written normally.
                    if (r_state != S_IDLE) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                    r_wr_en   <= 1'b1;
                    r_wr_page <= r_page;
                    r_wr_col  <= r_col;
                    r_wr_data <= r_byte_data;
                    r_col     <= w_col_nxt;
                    r_page    <= w_page_nxt;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            case (r_byte_data)
                                8'hAE, 8'hAF: r_disp_on   <= r_byte_data[0];
                                8'hA4, 8'hA5: r_entire_on <= r_byte_data[0];
                                8'h8D, 8'h81, 8'hD9, 8'h20, 8'h21, 8'h22: begin
                                    r_opcode <= r_byte_data;
                                    r_state  <= S_ARG1;
                                end
                                default: r_cmd_err <= 1'b1;
                            endcase
                        end
                        S_ARG1: begin
                            r_state <= S_IDLE;
                            case (r_opcode)
                                8'h8D: r_charge_pump <= r_byte_data[2];
                                8'h81: r_contrast    <= r_byte_data;
                                8'hD9: r_precharge   <= r_byte_data;
                                8'h20: r_addr_mode   <= r_byte_data[1:0];
                                default: begin
                                    r_arg1  <= r_byte_data[6:0];
                                    r_state <= S_ARG2;
                                end
                            endcase
                        end
                        S_ARG2: begin
                            r_state <= S_IDLE;
                            if (r_opcode == 8'h21) begin
                                r_col_start <= r_arg1;
                                r_col_end   <= r_byte_data[6:0];
                                r_col       <= r_arg1;
                            end else begin
                                r_page_start <= r_arg1[2:0];
                                r_page_end   <= r_byte_data[2:0];
                                r_page       <= r_arg1[2:0];
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef OLED_RX_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_byte_valid & r_byte_dc & ~r_addr_mode[1] &
                            (r_col == r_col_end) & (r_page == r_page_end);
        end
    end

    assign o_frame_done = r_frame_done;
`else
    assign o_frame_done = 1'b0;
`endif

    assign o_byte_valid  = r_byte_valid;
    assign o_byte_data   = r_byte_data;
    assign o_byte_dc     = r_byte_dc;
    assign o_disp_on     = r_disp_on;
    assign o_entire_on   = r_entire_on;
    assign o_charge_pump = r_charge_pump;
    assign o_contrast    = r_contrast;
    assign o_precharge   = r_precharge;
    assign o_addr_mode   = r_addr_mode;
    assign o_wr_en       = r_wr_en;
    assign o_wr_page     = r_wr_page;
    assign o_wr_col      = r_wr_col;
    assign o_wr_data     = r_wr_data;
    assign o_cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_spi_rx
// Brief    : Directed self-checking bench for oled_spi_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_spi_rx;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       disp_on;
    logic       entire_on;
    logic       charge_pump;
    logic [7:0] contrast;
    logic [7:0] precharge;
    logic [1:0] addr_mode;
    logic       wr_en;
    logic [2:0] wr_page;
    logic [6:0] wr_col;
    logic [7:0] wr_data;
    logic       cmd_err;
    logic       frame_done;

    oled_spi_rx_if spi ();

    oled_spi_rx #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi           (spi),
        .o_byte_valid  (byte_valid),
        .o_byte_data   (byte_data),
        .o_byte_dc     (byte_dc),
        .o_disp_on     (disp_on),
        .o_entire_on   (entire_on),
        .o_charge_pump (charge_pump),
        .o_contrast    (contrast),
        .o_precharge   (precharge),
        .o_addr_mode   (addr_mode),
        .o_wr_en       (wr_en),
        .o_wr_page     (wr_page),
        .o_wr_col      (wr_col),
        .o_wr_data     (wr_data),
        .o_cmd_err     (cmd_err),
        .o_frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_bytes = 0;
    int          n_err   = 0;
    int          n_both  = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [18:0] wq[$];

    // Entries are {page, col, data, frame_done}.
    always @(negedge clk) begin
        if (byte_valid) begin
            n_bytes   <= n_bytes + 1;
            last_byte <= byte_data;
        end
        if (cmd_err) n_err <= n_err + 1;
        if (cmd_err && wr_en) n_both <= n_both + 1;
        if (wr_en) wq.push_back({wr_page, wr_col, wr_data, frame_done});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        spi.mosi = b;
        spi.dc   = d;
        #40 spi.sck = 1'b1;
        #40 spi.sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        spi.cs_n = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
        repeat (6) @(posedge clk);
    endtask

    task automatic send_cmds(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i], 1'b0);
    endtask

    logic [18:0] exp_w[5];
    int          err0;
    int          bytes0;

    initial begin
        spi.sck  = 1'b0;
        spi.mosi = 1'b0;
        spi.dc   = 1'b0;
        spi.cs_n = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_contrast",  contrast,  8'h7F);
        check("rst_precharge", precharge, 8'h22);
        check("rst_addr_mode", addr_mode, 2'b10);
        check("rst_strobes", {byte_valid, wr_en, cmd_err, frame_done, disp_on, entire_on, charge_pump}, 7'b0);

        send_cmds('{8'h8D, 8'h14, 8'h20, 8'h00, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hA4, 8'hAF});
        @(negedge clk);
        check("cfg_charge_pump", charge_pump, 1'b1);
        check("cfg_addr_mode",   addr_mode,   2'b00);
        check("cfg_contrast",    contrast,    8'hCF);
        check("cfg_precharge",   precharge,   8'hF1);
        check("cfg_entire_on",   entire_on,   1'b0);
        check("cfg_disp_on",     disp_on,     1'b1);
        check("cfg_no_err",      n_err,       0);
        check("cfg_byte_count",  n_bytes,     10);

        wq.delete();
        send_cmds('{8'h22, 8'h00, 8'hFF, 8'h21, 8'h00, 8'h7F});
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        @(negedge clk);
        check("horz_nwrites", wq.size(), 3);
        if (wq.size() == 3) begin
            check("horz_w0", wq[0], {3'd0, 7'd0, 8'h01, 1'b0});
            check("horz_w1", wq[1], {3'd0, 7'd1, 8'h02, 1'b0});
            check("horz_w2", wq[2], {3'd0, 7'd2, 8'h03, 1'b0});
        end

        wq.delete();
        send_cmds('{8'h21, 8'h7E, 8'h7F, 8'h22, 8'h06, 8'h07});
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
        @(negedge clk);
        exp_w[0] = {3'd6, 7'd126, 8'h10, 1'b0};
        exp_w[1] = {3'd6, 7'd127, 8'h11, 1'b0};
`ifdef OLED_RX_FRAME_DONE_EN
        exp_w[3] = {3'd7, 7'd127, 8'h13, 1'b1};
`else
        exp_w[3] = {3'd7, 7'd127, 8'h13, 1'b0};
`endif
        exp_w[2] = {3'd7, 7'd126, 8'h12, 1'b0};
        exp_w[4] = {3'd6, 7'd126, 8'h14, 1'b0};
        check("wrap_nwrites", wq.size(), 5);
        if (wq.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("wrap_w%0d", i), wq[i], exp_w[i]);
        end

        send_byte(8'hAE, 1'b0);
        @(negedge clk);
        check("frm_disp_off", disp_on, 1'b0);
        bytes0 = n_bytes;
        spi.cs_n = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        spi.cs_n = 1'b1;
        repeat (4) @(posedge clk);
        send_byte(8'hAF, 1'b0);
        @(negedge clk);
        check("frm_one_byte", n_bytes - bytes0, 1);
        check("frm_byte_val", last_byte, 8'hAF);
        check("frm_disp_on",  disp_on, 1'b1);

        wq.delete();
        err0 = n_err;
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        check("err_unknown", n_err - err0, 1);
        check("err_unk_nochange", {disp_on, addr_mode, contrast}, {1'b1, 2'b00, 8'hCF});
        send_byte(8'h81, 1'b0);
        send_byte(8'h55, 1'b1);
        @(negedge clk);
        check("err_abort",     n_err - err0, 2);
        check("err_same_cyc",  n_both, 1);
        check("err_contrast",  contrast, 8'hCF);
        check("err_nwrites",   wq.size(), 1);
        if (wq.size() == 1) check("err_write", wq[0], {3'd6, 7'd127, 8'h55, 1'b0});
        send_byte(8'hAE, 1'b0);
        @(negedge clk);
        check("err_idle_after", {disp_on, contrast}, {1'b0, 8'hCF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
